buffer_b_hs: RTL

Parametrised next-generation ID/EX pipeline register. Carries the same field set as the current ID/EX stage: PC+4, RD1, RD2, sign-extended immediate, two register specifiers and jump target. Adds a control bundle, a valid/ready handshake with a 2-entry skid so back-pressure never drops an instruction, and a synchronous flush for branch/jump squash. Sits between decode/register-file read and execute.

---
 rtl/buffer_b_hs.sv | 125 ++++++++++++
 1 files changed

// File: rtl/buffer_b_hs.sv
// buffer_b_hs: ID/EX pipeline register with valid/ready handshake, a
// 2-entry skid (main + skid register) and synchronous flush.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   flush             squash all held entries (next state EMPTY)
//   in_valid/in_ready upstream handshake; in_ready depends on state only
//   inAdder..inJump   DATA_W payload fields (PC+4, RD1, RD2, sign-ext, jump)
//   inInsA/inInsB     REG_W register specifiers
//   inCtrl            CTRL_W control bundle (all-zero = NOP)
//   out_valid/out_ready downstream handshake
//   out*              registered payload; outCtrl forced 0 while out_valid=0
//   occupancy         entries held (0..2)
module buffer_b_hs #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] inAdder,
    input  logic [DATA_W-1:0] inRD1,
    input  logic [DATA_W-1:0] inRD2,
    input  logic [DATA_W-1:0] inSignExt,
    input  logic [DATA_W-1:0] inJump,
    input  logic [REG_W-1:0]  inInsA,
    input  logic [REG_W-1:0]  inInsB,
    input  logic [CTRL_W-1:0] inCtrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] outAdder,
    output logic [DATA_W-1:0] outRD1,
    output logic [DATA_W-1:0] outRD2,
    output logic [DATA_W-1:0] outSignExt,
    output logic [DATA_W-1:0] outJump,
    output logic [REG_W-1:0]  outInsA,
    output logic [REG_W-1:0]  outInsB,
    output logic [CTRL_W-1:0] outCtrl,
    output logic [1:0]        occupancy
);

    localparam int PW = 5*DATA_W + 2*REG_W + CTRL_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   in_bus, main_q, skid_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic            accept, drain;
    logic            load_main_in, load_main_skid, load_skid;

    // All payload fields travel as one flat word through both registers.
    assign in_bus = {inAdder, inRD1, inRD2, inSignExt, inJump, inInsA, inInsB, inCtrl};

    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign occupancy = state;
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        // Flush drops any same-cycle accept; a same-cycle drain has already
        // been consumed downstream, so emptying is correct either way.
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        state_nxt    = ONE;
                        load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        state_nxt = TWO;
                        load_skid = 1'b1;
                    end else if (drain) begin
                        state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    if (drain) begin
                        state_nxt      = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in)        main_q <= in_bus;
            else if (load_main_skid) main_q <= skid_q;
            if (load_skid)           skid_q <= in_bus;
        end
    end

    assign {outAdder, outRD1, outRD2, outSignExt, outJump, outInsA, outInsB, ctrl_q} = main_q;
    assign outCtrl = out_valid ? ctrl_q : '0;

endmodule
